// File: rtl/addsub_issue_q.sv
// addsub_issue_q: circular-buffer issue queue feeding addsub with registered operands,
// a one-cycle load strobe per issued operation, occupancy and a wrapping issue count.
module addsub_issue_q #(
   parameter int data_size = 15,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_add_sub,
   input  logic [data_size-1:0]   in_dataa,
   input  logic [data_size-1:0]   in_datab,
   input  logic                   out_hold,
   input  logic                   flush,
   output logic                   add_sub,
   output logic [data_size-1:0]   dataa,
   output logic [data_size-1:0]   datab,
   output logic                   load,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_W-1:0]       issue_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2 * data_size + 1;
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   logic [EW-1:0]        mem_q [DEPTH];
   logic [EW-1:0]        mem_d [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]          cnt_q, cnt_d;
   logic                 add_sub_q, add_sub_d, load_q, load_d;
   logic [data_size-1:0] dataa_q, dataa_d, datab_q, datab_d;
   logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
   logic                 push, pop;

   assign in_ready  = cnt_q != FULL;
   assign add_sub   = add_sub_q;
   assign dataa     = dataa_q;
   assign datab     = datab_q;
   assign load      = load_q;
   assign level     = cnt_q;
   assign issue_cnt = issue_cnt_q;

   // Readiness ignores a same-cycle pop, so a full queue refuses a push even while draining.
   always_comb begin
      push        = in_valid && in_ready && !flush;
      pop         = !out_hold && cnt_q != '0 && !flush;
      mem_d       = mem_q;
      wr_ptr_d    = flush ? '0 : wr_ptr_q + AW'(push);
      rd_ptr_d    = flush ? '0 : rd_ptr_q + AW'(pop);
      cnt_d       = flush ? '0 : cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
      issue_cnt_d = flush ? '0 : issue_cnt_q + CNT_W'(pop);
      load_d      = pop;
      add_sub_d   = add_sub_q;
      dataa_d     = dataa_q;
      datab_d     = datab_q;
      if (pop) {add_sub_d, dataa_d, datab_d} = mem_q[rd_ptr_q];
      if (push) mem_d[wr_ptr_q] = {in_add_sub, in_dataa, in_datab};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         issue_cnt_q <= '0;
         load_q      <= 1'b0;
         add_sub_q   <= 1'b0;
         dataa_q     <= '0;
         datab_q     <= '0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         issue_cnt_q <= issue_cnt_d;
         load_q      <= load_d;
         add_sub_q   <= add_sub_d;
         dataa_q     <= dataa_d;
         datab_q     <= datab_d;
      end
   end
endmodule

// File: tb/tb_addsub_issue_q.sv
// tb_addsub_issue_q: directed vector table, queue-based reference model under random
// traffic, streaming and asynchronous-reset sequences for addsub_issue_q.
module tb_addsub_issue_q;
   localparam int W = 15, D = 4, CW = 16;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          in_valid = 1'b0, in_add_sub = 1'b0, out_hold = 1'b0, flush = 1'b0;
   logic [W-1:0]  in_dataa = '0, in_datab = '0;
   logic          in_ready, add_sub, load;
   logic [W-1:0]  dataa, datab;
   logic [2:0]    level;
   logic [CW-1:0] issue_cnt;

   int n_vec = 0, n_err = 0;

   addsub_issue_q #(.data_size(W), .DEPTH(D), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_add_sub(in_add_sub), .in_dataa(in_dataa), .in_datab(in_datab),
      .out_hold(out_hold), .flush(flush), .add_sub(add_sub), .dataa(dataa),
      .datab(datab), .load(load), .level(level), .issue_cnt(issue_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int v, as, a, b, h, f, e_ld, e_as, e_a, e_b, e_lv, e_rdy, e_cnt;
   } vec_t;
   vec_t tbl[20];

   // Reference model: a plain FIFO of requests plus the last issued operation.
   logic [2*W:0]  mq[$];
   logic          m_as, m_ld;
   logic [W-1:0]  m_a, m_b;
   logic [CW-1:0] m_cnt;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(logic v, logic as, logic [W-1:0] a, logic [W-1:0] b, logic h, logic f);
      in_valid = v; in_add_sub = as; in_dataa = a; in_datab = b; out_hold = h; flush = f;
   endtask

   task automatic model_reset();
      mq.delete(); m_as = 0; m_ld = 0; m_a = '0; m_b = '0; m_cnt = '0;
   endtask

   task automatic model_step();
      bit rdy = mq.size() != D;
      if (flush) begin
         mq.delete(); m_cnt = '0; m_ld = 0;
      end else begin
         if (!out_hold && mq.size() != 0) begin
            {m_as, m_a, m_b} = mq.pop_front();
            m_ld = 1; m_cnt++;
         end else m_ld = 0;
         if (in_valid && rdy) mq.push_back({in_add_sub, in_dataa, in_datab});
      end
   endtask

   task automatic check_model(string tag);
      chk({tag, "_load"}, 32'(load), 32'(m_ld));
      chk({tag, "_add_sub"}, 32'(add_sub), 32'(m_as));
      chk({tag, "_dataa"}, 32'(dataa), 32'(m_a));
      chk({tag, "_datab"}, 32'(datab), 32'(m_b));
      chk({tag, "_level"}, 32'(level), 32'(mq.size()));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(mq.size() != D));
      chk({tag, "_issue_cnt"}, 32'(issue_cnt), 32'(m_cnt));
   endtask

   task automatic mcycle(string tag, logic v, logic as, logic [W-1:0] a, logic [W-1:0] b, logic h, logic f);
      drive(v, as, a, b, h, f);
      model_step();
      @(posedge clk); #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      rst_n = 0;
      drive(0, 0, '0, '0, 0, 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   initial begin
      int loads, max_lv;
      tbl[0]  = '{1, 1, 5, 3, 0, 0,             0, 0, 0, 0, 1, 1, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 0,             1, 1, 5, 3, 0, 1, 1};
      tbl[2]  = '{0, 0, 0, 0, 0, 0,             0, 1, 5, 3, 0, 1, 1};
      tbl[3]  = '{1, 0, 'h11, 'h22, 1, 0,       0, 1, 5, 3, 1, 1, 1};
      tbl[4]  = '{1, 1, 'h33, 'h44, 1, 0,       0, 1, 5, 3, 2, 1, 1};
      tbl[5]  = '{1, 0, 'h55, 'h66, 1, 0,       0, 1, 5, 3, 3, 1, 1};
      tbl[6]  = '{1, 1, 'h77, 'h7fff, 1, 0,     0, 1, 5, 3, 4, 0, 1};
      tbl[7]  = '{1, 1, 1, 1, 1, 0,             0, 1, 5, 3, 4, 0, 1};
      tbl[8]  = '{1, 1, 'h100, 'h200, 0, 0,     1, 0, 'h11, 'h22, 3, 1, 2};
      tbl[9]  = '{1, 1, 'h100, 'h200, 0, 0,     1, 1, 'h33, 'h44, 3, 1, 3};
      tbl[10] = '{0, 0, 0, 0, 0, 0,             1, 0, 'h55, 'h66, 2, 1, 4};
      tbl[11] = '{0, 0, 0, 0, 1, 0,             0, 0, 'h55, 'h66, 2, 1, 4};
      tbl[12] = '{0, 0, 0, 0, 0, 0,             1, 1, 'h77, 'h7fff, 1, 1, 5};
      tbl[13] = '{0, 0, 0, 0, 0, 0,             1, 1, 'h100, 'h200, 0, 1, 6};
      tbl[14] = '{0, 0, 0, 0, 0, 0,             0, 1, 'h100, 'h200, 0, 1, 6};
      tbl[15] = '{1, 0, 'ha, 'hb, 1, 0,         0, 1, 'h100, 'h200, 1, 1, 6};
      tbl[16] = '{1, 1, 'hc, 'hd, 1, 0,         0, 1, 'h100, 'h200, 2, 1, 6};
      tbl[17] = '{1, 0, 'he, 'hf, 1, 0,         0, 1, 'h100, 'h200, 3, 1, 6};
      tbl[18] = '{1, 1, 'h3f, 'h3f, 0, 1,       0, 1, 'h100, 'h200, 0, 1, 0};
      tbl[19] = '{0, 0, 0, 0, 0, 0,             0, 1, 'h100, 'h200, 0, 1, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_level", 32'(level), 0);
      chk("rst_load", 32'(load), 0);
      chk("rst_issue_cnt", 32'(issue_cnt), 0);
      chk("rst_data", 32'({add_sub, dataa, datab}), 0);
      rst_n = 1;

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].v[0], tbl[i].as[0], W'(tbl[i].a), W'(tbl[i].b), tbl[i].h[0], tbl[i].f[0]);
         @(posedge clk); #1;
         chk($sformatf("row%0d_load", i), 32'(load), tbl[i].e_ld);
         chk($sformatf("row%0d_add_sub", i), 32'(add_sub), tbl[i].e_as);
         chk($sformatf("row%0d_dataa", i), 32'(dataa), tbl[i].e_a);
         chk($sformatf("row%0d_datab", i), 32'(datab), tbl[i].e_b);
         chk($sformatf("row%0d_level", i), 32'(level), tbl[i].e_lv);
         chk($sformatf("row%0d_in_ready", i), 32'(in_ready), tbl[i].e_rdy);
         chk($sformatf("row%0d_issue_cnt", i), 32'(issue_cnt), tbl[i].e_cnt);
      end

      do_reset();
      for (int i = 0; i < 400; i++)
         mcycle($sformatf("rnd%0d", i), $urandom_range(0, 9) < 7, 1'($urandom),
                W'($urandom), W'($urandom), $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3);

      do_reset();
      loads = 0; max_lv = 0;
      for (int i = 0; i < 10; i++) begin
         mcycle($sformatf("stream%0d", i), i < 8, 1'(i), W'(i + 1), W'(2 * i + 7), 0, 0);
         loads += int'(load);
         if (int'(level) > max_lv) max_lv = int'(level);
      end
      chk("stream_loads", 32'(loads), 8);
      chk("stream_max_level", 32'(max_lv), 1);
      chk("stream_issue_cnt", 32'(issue_cnt), 8);

      do_reset();
      for (int i = 0; i < 3; i++) mcycle($sformatf("arst_fill%0d", i), 1, 1, W'(i + 9), W'(i + 3), 1, 0);
      mcycle("arst_pop", 0, 0, '0, '0, 0, 0);
      chk("arst_pre_level", 32'(level), 2);
      chk("arst_pre_load", 32'(load), 1);
      #2 rst_n = 0;
      #1;
      chk("arst_level", 32'(level), 0);
      chk("arst_load", 32'(load), 0);
      chk("arst_in_ready", 32'(in_ready), 1);
      chk("arst_issue_cnt", 32'(issue_cnt), 0);
      chk("arst_data", 32'({add_sub, dataa, datab}), 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      mcycle("arst_after0", 0, 0, '0, '0, 0, 0);
      mcycle("arst_after1", 1, 0, W'(21), W'(4), 0, 0);
      mcycle("arst_after2", 0, 0, '0, '0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
